// File: rtl/wb_fifo_port.sv
// wb_fifo_port: Wishbone classic slave exposing a 32-bit word FIFO, its status, a 16-bit GPIO
// output register (driven onto user I/O [31:16]) and an optional threshold interrupt.
//
// Optional feature macro: WB_FIFO_PORT_IRQ_EN
//   defined   -> THRESH register is read/write; irq_o is a registered level interrupt
//   undefined -> THRESH reads 0, writes are acked and dropped; irq_o tied low
//
// Ports:
//   wb_clk_i, wb_rstn_i      clock, asynchronous active-low reset
//   wbs_cyc_i/stb_i/we_i     Wishbone cycle, strobe, write enable
//   wbs_sel_i[3:0]           byte enables (used by GPIO only)
//   wbs_adr_i[31:0]          byte address; window is adr[31:8] == BASE_ADDR[31:8]
//   wbs_dat_i[31:0]          write data
//   wbs_ack_o, wbs_dat_o     acknowledge (one cycle) and read data (valid while ack is high)
//   io_out[15:0]             GPIO output value
//   io_oeb[15:0]             GPIO output enables, active-low
//   irq_o                    level interrupt
//
// Register map (offset): 0x00 DATA push/pop, 0x04 STATUS (W1C [3:2]), 0x08 GPIO, 0x0C THRESH.

module wb_fifo_port #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AW        = 3
) (
  input  logic        wb_clk_i,
  input  logic        wb_rstn_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [15:0] io_out,
  output logic [15:0] io_oeb,
  output logic        irq_o
);

  localparam logic [AW:0] DepthCnt = (AW + 1)'(DEPTH);

  logic          r_ack;
  logic [31:0]   r_dat;
  logic [15:0]   r_io_out;
  logic [15:0]   r_io_oeb;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_ovf;
  logic          r_udf;
  logic [31:0]   r_mem [DEPTH];

  logic          w_req;
  logic          w_empty;
  logic          w_full;
  logic [31:0]   w_status;
  logic          w_push;
  logic          w_pop;
  logic          w_ovf_set;
  logic          w_udf_set;
  logic          w_sts_wr;
  logic          w_gpio_wr;
  logic [31:0]   w_rdata;
  logic [1:0]    w_unused_adr;

  assign w_unused_adr = wbs_adr_i[1:0];

  // The ~r_ack term makes a held strobe see a gap cycle, giving ack every other cycle.
  assign w_req = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~r_ack;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DepthCnt);

  always_comb begin
    w_status          = '0;
    w_status[0]       = w_empty;
    w_status[1]       = w_full;
    w_status[2]       = r_ovf;
    w_status[3]       = r_udf;
    w_status[AW+8:8]  = r_count;
  end

`ifdef WB_FIFO_PORT_IRQ_EN
  logic [AW:0] r_thresh;
  logic        r_irq;
  logic        w_thr_wr;
`endif

  // Request decode: all side effects happen on the edge that raises ack.
  always_comb begin
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_ovf_set = 1'b0;
    w_udf_set = 1'b0;
    w_sts_wr  = 1'b0;
    w_gpio_wr = 1'b0;
    w_rdata   = '0;
`ifdef WB_FIFO_PORT_IRQ_EN
    w_thr_wr  = 1'b0;
`endif
    if (w_req) begin
      case (wbs_adr_i[7:2])
        6'h00: begin
          if (wbs_we_i) begin
            if (w_full) w_ovf_set = 1'b1;
            else        w_push    = 1'b1;
          end else begin
            if (w_empty) begin
              w_udf_set = 1'b1;
            end else begin
              w_pop   = 1'b1;
              w_rdata = r_mem[r_rptr];
            end
          end
        end
        6'h01: begin
          if (wbs_we_i) w_sts_wr = 1'b1;
          else          w_rdata  = w_status;
        end
        6'h02: begin
          if (wbs_we_i) w_gpio_wr = 1'b1;
          else          w_rdata   = {r_io_oeb, r_io_out};
        end
        6'h03: begin
`ifdef WB_FIFO_PORT_IRQ_EN
          if (wbs_we_i) w_thr_wr = 1'b1;
          else          w_rdata  = 32'(r_thresh);
`endif
        end
        default: ;  // in-window unmapped: acked, reads 0, writes dropped
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_push) r_mem[r_wptr] <= wbs_dat_i;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      r_ack    <= 1'b0;
      r_dat    <= '0;
      r_io_out <= '0;
      r_io_oeb <= 16'hFFFF;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_ack <= w_req;
      r_dat <= w_rdata;
      if (w_push) begin
        r_wptr  <= r_wptr + 1'b1;
        r_count <= r_count + 1'b1;
      end else if (w_pop) begin
        r_rptr  <= r_rptr + 1'b1;
        r_count <= r_count - 1'b1;
      end
      r_ovf <= (r_ovf & ~(w_sts_wr & wbs_dat_i[2])) | w_ovf_set;
      r_udf <= (r_udf & ~(w_sts_wr & wbs_dat_i[3])) | w_udf_set;
      if (w_gpio_wr) begin
        if (wbs_sel_i[0]) r_io_out[7:0]  <= wbs_dat_i[7:0];
        if (wbs_sel_i[1]) r_io_out[15:8] <= wbs_dat_i[15:8];
        if (wbs_sel_i[2]) r_io_oeb[7:0]  <= wbs_dat_i[23:16];
        if (wbs_sel_i[3]) r_io_oeb[15:8] <= wbs_dat_i[31:24];
      end
    end
  end

`ifdef WB_FIFO_PORT_IRQ_EN
  // irq samples state already updated by the ack edge, so it lags that ack by one cycle.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      r_thresh <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (w_thr_wr) r_thresh <= wbs_dat_i[AW:0];
      r_irq <= ((r_count >= r_thresh) && (r_thresh != '0)) || r_ovf || r_udf;
    end
  end
  assign irq_o = r_irq;
`else
  assign irq_o = 1'b0;
`endif

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign io_out    = r_io_out;
  assign io_oeb    = r_io_oeb;

endmodule
